// File: rtl/mul_issue_ctrl.sv
// Execute-stage wrapper around the iterative unsigned multiplier: converts RV64M operands to
// magnitudes, runs the start/done handshake, applies sign fix-up and high/low/W selection.
module mul_issue_ctrl #(
  parameter int XLEN = 64,
  parameter int OP_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [XLEN-1:0]   in_src1,
  input  logic [XLEN-1:0]   in_src2,
  input  logic [4:0]        in_rd,
  input  logic              flush,
  output logic              mul_start,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  input  logic              mul_done,
  input  logic [2*XLEN-1:0] mul_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [4:0]        out_rd
);

  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(3'd0);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(3'd1);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(3'd2);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(3'd3);
  localparam logic [OP_W-1:0] OP_MULW   = OP_W'(3'd4);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIX   = 3'd3,
    ST_RESP  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  state_t              state_r;
  logic [OP_W-1:0]     op_r;
  logic                neg_r;
  logic [2*XLEN-1:0]   prod_r;

  logic                s1_signed_s;
  logic                s2_signed_s;
  logic                reserved_s;
  logic                shortcut_s;
  logic                neg_s;
  logic [XLEN-1:0]     a_masked_s;
  logic [XLEN-1:0]     b_masked_s;
  logic [XLEN-1:0]     a_mag_s;
  logic [XLEN-1:0]     b_mag_s;
  logic [2*XLEN-1:0]   fixed_s;
  logic [XLEN-1:0]     sel_s;

  // The most negative value maps to 2^(XLEN-1), which is representable as an unsigned magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
    if (is_signed && v[XLEN-1]) begin
      magnitude = ~v + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  // Operand decode: signedness, masking, magnitudes and the zero/reserved shortcut.
  always_comb begin
    s1_signed_s = 1'b0;
    s2_signed_s = 1'b0;
    reserved_s  = 1'b0;
    a_masked_s  = in_src1;
    b_masked_s  = in_src2;
    case (in_op)
      OP_MUL, OP_MULH: begin
        s1_signed_s = 1'b1;
        s2_signed_s = 1'b1;
      end
      OP_MULHSU: begin
        s1_signed_s = 1'b1;
      end
      OP_MULHU: begin
        s1_signed_s = 1'b0;
      end
      OP_MULW: begin
        a_masked_s = {{(XLEN-32){1'b0}}, in_src1[31:0]};
        b_masked_s = {{(XLEN-32){1'b0}}, in_src2[31:0]};
      end
      default: begin
        reserved_s = 1'b1;
      end
    endcase
    neg_s      = (s1_signed_s & in_src1[XLEN-1]) ^ (s2_signed_s & in_src2[XLEN-1]);
    a_mag_s    = magnitude(a_masked_s, s1_signed_s);
    b_mag_s    = magnitude(b_masked_s, s2_signed_s);
    shortcut_s = reserved_s | (a_masked_s == {XLEN{1'b0}}) | (b_masked_s == {XLEN{1'b0}});
  end

  // Sign fix-up of the captured product and result selection.
  always_comb begin
    if (neg_r) begin
      fixed_s = ~prod_r + {{(2*XLEN-1){1'b0}}, 1'b1};
    end else begin
      fixed_s = prod_r;
    end
    case (op_r)
      OP_MUL:                       sel_s = fixed_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: sel_s = fixed_s[2*XLEN-1:XLEN];
      OP_MULW:                      sel_s = {{(XLEN-32){fixed_s[31]}}, fixed_s[31:0]};
      default:                      sel_s = {XLEN{1'b0}};
    endcase
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      in_ready   <= 1'b1;
      mul_start  <= 1'b0;
      mul_a      <= {XLEN{1'b0}};
      mul_b      <= {XLEN{1'b0}};
      out_valid  <= 1'b0;
      out_result <= {XLEN{1'b0}};
      out_rd     <= 5'd0;
      op_r       <= {OP_W{1'b0}};
      neg_r      <= 1'b0;
      prod_r     <= {(2*XLEN){1'b0}};
    end else begin
      mul_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid && !flush) begin
            op_r     <= in_op;
            out_rd   <= in_rd;
            neg_r    <= neg_s;
            in_ready <= 1'b0;
            if (shortcut_s) begin
              out_result <= {XLEN{1'b0}};
              out_valid  <= 1'b1;
              state_r    <= ST_RESP;
            end else begin
              mul_a     <= a_mag_s;
              mul_b     <= b_mag_s;
              mul_start <= 1'b1;
              state_r   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // The start pulse has already gone out, so a flush here must still drain.
          state_r <= flush ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          if (mul_done) begin
            if (flush) begin
              in_ready <= 1'b1;
              state_r  <= ST_IDLE;
            end else begin
              prod_r  <= mul_p;
              state_r <= ST_FIX;
            end
          end else if (flush) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_FIX: begin
          if (flush) begin
            in_ready <= 1'b1;
            state_r  <= ST_IDLE;
          end else begin
            out_result <= sel_s;
            out_valid  <= 1'b1;
            state_r    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (mul_done) begin
            in_ready <= 1'b1;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: directed RV64M cases plus randomized traffic,
// checked every cycle against a transaction-level model and a behavioural multiplier.
module tb_mul_issue_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'd0;
  logic [63:0]  in_src1 = 64'd0;
  logic [63:0]  in_src2 = 64'd0;
  logic [4:0]   in_rd = 5'd0;
  logic         flush = 1'b0;
  logic         mul_start;
  logic [63:0]  mul_a;
  logic [63:0]  mul_b;
  logic         mul_done = 1'b0;
  logic [127:0] mul_p = 128'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_result;
  logic [4:0]   out_rd;

  mul_issue_ctrl #(.XLEN(64), .OP_W(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd), .flush(flush),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_starts = 0;
  int first_valid = -1;
  bit prev_ov = 1'b0;

  // transaction model: where the current op is in its life
  bit m_busy, m_issue, m_await, m_fix, m_resp, m_drain;
  logic [63:0] m_res, m_a, m_b;
  logic [4:0]  m_rd;
  int          m_acc_cyc;
  bit          m_lit_en = 1'b0;
  logic [63:0] m_lit = 64'd0;

  // behavioural multiplier
  bit           x_busy = 1'b0;
  int           x_cnt = 0;
  int           x_lat = 1;
  logic [127:0] x_a, x_b;
  bit           spur_en = 1'b0;
  bit           obs_start = 1'b0;
  logic [63:0]  obs_a, obs_b;

  function automatic bit sgn1(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd2);
  endfunction

  function automatic bit sgn2(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1);
  endfunction

  function automatic logic [63:0] msk(input logic [2:0] op, input logic [63:0] v);
    return (op == 3'd4) ? {32'd0, v[31:0]} : v;
  endfunction

  function automatic logic [63:0] mag(input logic [63:0] v, input bit s);
    return (s && v[63]) ? (64'd0 - v) : v;
  endfunction

  // Reference result from a full-width two's-complement product.
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    if (op > 3'd4) return 64'd0;
    ea = sgn1(op) ? {{64{a[63]}}, a} : {64'd0, msk(op, a)};
    eb = sgn2(op) ? {{64{b[63]}}, b} : {64'd0, msk(op, b)};
    p = ea * eb;
    case (op)
      3'd0:    return p[63:0];
      3'd4:    return {{32{p[31]}}, p[31:0]};
      default: return p[127:64];
    endcase
  endfunction

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'd1;
      4:       return {32'hFFFF_FFFF, 32'($urandom)};
      5:       return {32'($urandom), 32'd0};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_issue = 0; m_await = 0; m_fix = 0; m_resp = 0; m_drain = 0;
    x_busy = 0; obs_start = 0; prev_ov = 0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_update();
    if (!m_busy) begin
      if (in_valid && !flush) begin
        m_busy    = 1;
        m_acc_cyc = cyc;
        m_rd      = in_rd;
        m_res     = ref_res(in_op, in_src1, in_src2);
        m_a       = mag(msk(in_op, in_src1), sgn1(in_op));
        m_b       = mag(msk(in_op, in_src2), sgn2(in_op));
        if (in_op > 3'd4 || msk(in_op, in_src1) == 64'd0 || msk(in_op, in_src2) == 64'd0) m_resp = 1;
        else m_issue = 1;
      end
    end else if (m_issue) begin
      m_issue = 0;
      if (flush) m_drain = 1; else m_await = 1;
    end else if (m_await) begin
      if (mul_done) begin
        m_await = 0;
        if (flush) m_busy = 0; else m_fix = 1;
      end else if (flush) begin
        m_await = 0;
        m_drain = 1;
      end
    end else if (m_fix) begin
      m_fix = 0;
      if (flush) m_busy = 0; else m_resp = 1;
    end else if (m_resp) begin
      if (flush || out_ready) begin
        m_resp = 0;
        m_busy = 0;
      end
    end else if (m_drain) begin
      if (mul_done) begin
        m_drain = 0;
        m_busy = 0;
      end
    end
  endtask

  task automatic compare();
    chk("in_ready", 64'(in_ready), 64'(!m_busy));
    chk("mul_start", 64'(mul_start), 64'(m_issue));
    if (m_issue || m_await) begin
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
    end
    chk("out_valid", 64'(out_valid), 64'(m_resp));
    if (m_resp) begin
      chk("out_result", out_result, m_res);
      chk("out_rd", 64'(out_rd), 64'(m_rd));
      if (m_lit_en) chk("literal_result", out_result, m_lit);
    end
    if (mul_start) n_starts++;
    if (out_valid && !prev_ov) first_valid = cyc;
    prev_ov   = out_valid;
    obs_start = mul_start;
    obs_a     = mul_a;
    obs_b     = mul_b;
  endtask

  task automatic cycle();
    bit real_done;
    real_done = x_busy && (x_cnt == 0);
    mul_done  = real_done || (spur_en && !x_busy && ($urandom_range(0, 7) == 0));
    mul_p     = real_done ? (x_a * x_b) : {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    @(posedge clk);
    cyc++;
    model_update();
    if (x_busy) begin
      if (x_cnt == 0) x_busy = 0; else x_cnt--;
    end
    if (obs_start) begin
      x_busy = 1;
      x_cnt  = x_lat;
      x_a    = {64'd0, obs_a};
      x_b    = {64'd0, obs_b};
    end
    #1;
    compare();
  endtask

  task automatic wait_idle();
    int g = 0;
    while (m_busy && g < 400) begin
      cycle();
      g++;
    end
    n_cmp++;
    if (m_busy) begin
      n_bad++;
      $display("FAIL timeout_idle @cyc %0d: got busy, want idle within 400 cycles", cyc);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input int lat, input int hold, input int flush_after,
                        input bit lit_en, input logic [63:0] lit, input int exp_lat, input int exp_starts);
    int held = 0;
    int s0;
    in_valid = 0; flush = 0; out_ready = 0; spur_en = 0;
    wait_idle();
    x_lat = lat; m_lit_en = lit_en; m_lit = lit; first_valid = -1; s0 = n_starts;
    in_valid = 1; in_op = op; in_src1 = a; in_src2 = b; in_rd = rd;
    cycle();
    in_valid = 0;
    if (flush_after >= 0) begin
      repeat (flush_after) cycle();
      flush = 1;
      cycle();
      flush = 0;
    end
    while (m_busy && held < 400) begin
      out_ready = m_resp && (held >= hold);
      if (m_resp) held++;
      if (!m_resp) held = (held < hold) ? held : held;
      cycle();
      if (!m_resp && m_busy) held = held;
    end
    wait_idle();
    out_ready = 0;
    m_lit_en = 0;
    if (exp_lat >= 0) chk("latency", 64'(first_valid - m_acc_cyc), 64'(exp_lat));
    if (exp_starts >= 0) chk("start_pulses", 64'(n_starts - s0), 64'(exp_starts));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mul_a", mul_a, 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    @(negedge clk);
    reset = 0;

    // hand-computed pins on the reference model
    chk("ref_mul", ref_res(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("ref_mulhu", ref_res(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("ref_mulh_m1", ref_res(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF), 64'd0);
    chk("ref_mulh_min", ref_res(3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000), 64'h4000_0000_0000_0000);
    chk("ref_mulhsu", ref_res(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ref_mulw", ref_res(3'd4, 64'h7FFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mag_m3", mag(64'hFFFF_FFFF_FFFF_FFFD, 1'b1), 64'd3);

    run_op(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 33, 0, -1, 1, 64'hFFFF_FFFF_FFFF_FFEB, 36, 1);
    run_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 3, 0, -1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 6, 1);
    run_op(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 2, 0, -1, 1, 64'd0, -1, 1);
    run_op(3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd6, 4, 0, -1, 1, 64'h4000_0000_0000_0000, -1, 1);
    run_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 1, 0, -1, 1, 64'hFFFF_FFFF_FFFF_FFFF, -1, 1);
    run_op(3'd4, 64'h7FFF_FFFF, 64'd2, 5'd8, 5, 0, -1, 1, 64'hFFFF_FFFF_FFFF_FFFE, -1, 1);
    run_op(3'd4, 64'hFFFF_FFFF_0000_0000, 64'd5, 5'd9, 5, 0, -1, 1, 64'd0, 0, 0);
    run_op(3'd0, 64'h1234, 64'd0, 5'd10, 5, 0, -1, 1, 64'd0, 0, 0);
    run_op(3'd6, 64'h1234, 64'h5678, 5'd11, 5, 0, -1, 1, 64'd0, 0, 0);

    // backpressure, then an immediate follow-on accept
    run_op(3'd0, 64'hDEAD_BEEF_0000_0003, 64'hFFFF_FFFF_FFFF_FFF0, 5'd12, 4, 10, -1, 0, 64'd0, -1, 1);
    chk("ready_after_handshake", 64'(in_ready), 64'd1);
    run_op(3'd3, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 5'd13, 2, 0, -1, 0, 64'd0, -1, 1);

    // flush in WAIT drains the outstanding product, then a normal op
    run_op(3'd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd11, 5'd14, 10, 0, 3, 0, 64'd0, -1, 1);
    chk("flush_no_valid", 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(3'd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd11, 5'd15, 3, 0, -1, 1, 64'hFFFF_FFFF_FFFF_FFFF, -1, 1);

    // async reset while waiting on the multiplier
    x_lat = 20; in_valid = 1; in_op = 3'd3; in_src1 = 64'h1234; in_src2 = 64'h55; in_rd = 5'd21;
    cycle();
    in_valid = 0;
    repeat (3) cycle();
    #2 reset = 1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_mul_start", 64'(mul_start), 64'd0);
    chk("arst_mul_a", mul_a, 64'd0);
    chk("arst_mul_b", mul_b, 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_result", out_result, 64'd0);
    chk("arst_out_rd", 64'(out_rd), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 0;
    cycle();

    // randomized traffic with flushes, backpressure and stray done pulses
    for (int i = 0; i < 4000; i++) begin
      spur_en   = 1;
      x_lat     = $urandom_range(1, 6);
      in_valid  = ($urandom_range(0, 1) == 1);
      in_op     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      in_src1   = pick_val();
      in_src2   = pick_val();
      in_rd     = 5'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      cycle();
    end
    in_valid = 0; flush = 0; out_ready = 1; spur_en = 0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
Execute-stage front/back end for the iterative unsigned multiplier. Accepts one decoded RV64M multiply op, converts operands to magnitudes, issues them to the multiplier over a start/done handshake, and captures the 2*XLEN product. It then applies sign correction and high/low/W selection, and returns the result with a valid/ready handshake. Stalls the pipeline (in_ready low) while an op is in flight.

Parameters:
XLEN, 64, operand/result width
OP_W, 3, opcode width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  op presented
in_ready  output  1  block can accept op (high only in IDLE)
in_op  input  OP_W  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5-7 reserved
in_src1  input  XLEN  rs1 value
in_src2  input  XLEN  rs2 value
in_rd  input  5  destination register
flush  input  1  squash in-flight op
mul_start  output  1  one-cycle start pulse to multiplier
mul_a  output  XLEN  unsigned multiplicand
mul_b  output  XLEN  unsigned multiplier
mul_done  input  1  product valid (sampled only in WAIT/DRAIN)
mul_p  input  2*XLEN  unsigned product
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  XLEN  final result
out_rd  output  5  destination register

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; mul_start=0; out_valid=0; mul_a/mul_b/out_result/out_rd/internal regs=0.
- States: IDLE, ISSUE, WAIT, FIX, RESP, DRAIN.
- IDLE: in_valid && !flush -> latch op, rd, and magnitudes plus neg flag. Next state:
  - RESP with result 0 if either masked operand is 0 or op is reserved.
  - ISSUE otherwise.
- Operand masking/sign:
  - MUL, MULH: both signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU: both unsigned.
  - MULW: src1[31:0] and src2[31:0] zero-extended, unsigned.
  - Magnitude of a negative signed operand is its two's complement; -2^(XLEN-1) maps to 2^(XLEN-1), no overflow.
  - neg = XOR of the sign bits that are treated as signed.
- ISSUE: mul_start=1 for exactly one cycle; mul_a/mul_b hold the magnitudes from ISSUE until leaving WAIT. Next state WAIT.
- WAIT: mul_done=1 -> capture mul_p, go to FIX. Otherwise stay; no timeout.
- FIX (one cycle): product = neg ? (~p + 1) mod 2^(2*XLEN) : p. Select:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - MULW: sign-extend product[31:0].
  - Next state RESP.
- RESP: out_valid=1; out_result and out_rd are stable until out_ready. out_valid && out_ready -> IDLE. No new accept in the same cycle.
- Minimum latency, accept edge to out_valid: multiplier latency L + 3 cycles (ISSUE, WAIT>=1, FIX). Zero/reserved shortcut: out_valid in the cycle after accept.
- Flush:
  - In IDLE: blocks acceptance.
  - In ISSUE or WAIT with mul_done=0: go to DRAIN.
  - In WAIT with mul_done=1, FIX, or RESP: discard and go to IDLE; out_valid drops next cycle.
- DRAIN: wait for mul_done, discard product, go to IDLE. in_ready=0. out_valid=0. A further flush has no effect. The multiplier cannot be aborted, so its outstanding done is always consumed.
- Flush and out_ready in the same cycle in RESP: flush wins; the result is not considered delivered.
- mul_done outside WAIT/DRAIN is ignored.

Test Plan:
- MUL src1=7, src2=0xFFFFFFFFFFFFFFFD (-3), multiplier model L=33 -> mul_a=7, mul_b=3, one mul_start pulse; out_result=0xFFFFFFFFFFFFFFEB at cycle accept+36.
- MULHU src1=src2=0xFFFFFFFFFFFFFFFF -> out_result=0xFFFFFFFFFFFFFFFE. MULH with the same operands -> 0x0000000000000000. MULH src1=src2=0x8000000000000000 -> 0x4000000000000000.
- MULHSU src1=-1, src2=2 -> out_result=0xFFFFFFFFFFFFFFFF. MULW src1=0x7FFFFFFF, src2=2 -> 0xFFFFFFFFFFFFFFFE. MULW src1=0xFFFFFFFF00000000, src2=5 -> 0.
- Zero/reserved: MUL src2=0 -> mul_start never asserts; out_valid in the cycle after accept; result 0. in_op=6 -> same behaviour.
- Backpressure: out_ready held low 10 cycles -> out_valid, out_result, out_rd stable; in_ready=0 throughout; accept resumes the cycle after the handshake.
- Flush during WAIT -> DRAIN; in_ready=0 until mul_done arrives; no out_valid. Next op's result is correct. Async reset mid-WAIT -> all outputs 0 and in_ready=1 immediately.
